usb_data_buffer: RTL and testbench

//  Shared 64-byte endpoint data FIFO between the AHB slave and the USB TX/RX cores.
//  TX path: AHB writes bytes, usb_tx reads them with get_tx_packet_data, gated by buffer_occupancy.
//  RX path: usb_rx pushes decoded bytes, AHB pops them.

---
 rtl/usb_data_buffer.sv | 85 ++++++++
 tb/tb_usb_data_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// Shared 64-byte endpoint FIFO between the AHB slave and the USB TX/RX cores.
// Show-ahead head byte on both read ports; occupancy is the count register itself.
module usb_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              flush,
   input  logic              store_tx_data,
   input  logic [7:0]        tx_data,
   input  logic              store_rx_packet_data,
   input  logic [7:0]        rx_packet_data,
   input  logic              get_tx_packet_data,
   input  logic              get_rx_data,
   output logic [7:0]        tx_packet_data,
   output logic [7:0]        rx_data,
   output logic [ADDR_W:0]   buffer_occupancy
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_t;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   fill_t             fill_state;

   logic       wipe, push_req, pop_req, push_ok, pop_ok;
   logic [7:0] push_byte;

   // Fill state is a pure decode of the count; no separate state register.
   always_comb begin
      fill_state = PARTIAL;
      if (count == '0)
         fill_state = EMPTY;
      else if (count == FULL_CNT)
         fill_state = FULL;
   end

   always_comb begin
      wipe      = clear | flush;
      push_req  = store_tx_data | store_rx_packet_data;
      pop_req   = get_tx_packet_data | get_rx_data;
      push_byte = store_tx_data ? tx_data : rx_packet_data;
      // Both judged on the pre-edge count: full drops push, empty ignores pop.
      push_ok   = push_req && (fill_state != FULL);
      pop_ok    = pop_req  && (fill_state != EMPTY);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (wipe) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (!wipe && push_ok) begin
         mem[wr_ptr] <= push_byte;
      end
   end

   assign tx_packet_data   = mem[rd_ptr];
   assign rx_data          = mem[rd_ptr];
   assign buffer_occupancy = count;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer: stimulus enqueues expected head bytes,
// a negedge monitor pops and compares them whenever a pop is presented.
module tb_usb_data_buffer;

   logic       tb_clk = 1'b0;
   logic       n_rst;
   logic       clear, flush;
   logic       store_tx_data, store_rx_packet_data;
   logic [7:0] tx_data, rx_packet_data;
   logic       get_tx_packet_data, get_rx_data;
   logic [7:0] tx_packet_data, rx_data;
   logic [6:0] buffer_occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];

   always #5 tb_clk = ~tb_clk;

   usb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk                  (tb_clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .flush                (flush),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .get_rx_data          (get_rx_data),
      .tx_packet_data       (tx_packet_data),
      .rx_data              (rx_data),
      .buffer_occupancy     (buffer_occupancy)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop must present the oldest outstanding byte.
   always @(negedge tb_clk) begin
      if (n_rst && (get_tx_packet_data || get_rx_data) && buffer_occupancy != 7'd0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL head_underrun: pop with occupancy %0d, expected none queued", buffer_occupancy);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("head_tx", int'(tx_packet_data), int'(e));
            check("head_rx", int'(rx_data), int'(e));
         end
      end
   end

   task automatic idle();
      store_tx_data = 0; store_rx_packet_data = 0;
      get_tx_packet_data = 0; get_rx_data = 0;
      clear = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge tb_clk);
      #1;
      idle();
   endtask

   task automatic push(input logic [7:0] b, input bit via_rx);
      if (via_rx) begin store_rx_packet_data = 1; rx_packet_data = b; end
      else        begin store_tx_data = 1;        tx_data = b;        end
      exp_q.push_back(b);
      tick();
   endtask

   task automatic pop(input bit via_rx);
      if (via_rx) get_rx_data = 1; else get_tx_packet_data = 1;
      tick();
   endtask

   initial begin
      idle();
      tx_data = 0; rx_packet_data = 0;
      n_rst = 0;
      #22;
      // T1: reset values
      check("rst_occ", int'(buffer_occupancy), 0);
      check("rst_tx",  int'(tx_packet_data), 0);
      check("rst_rx",  int'(rx_data), 0);
      n_rst = 1;
      @(posedge tb_clk); #1;
      push(8'hA5, 0);
      check("t1_occ1", int'(buffer_occupancy), 1);
      check("t1_head", int'(tx_packet_data), 8'hA5);
      pop(0);
      check("t1_occ0", int'(buffer_occupancy), 0);

      // T2: fill, overflow drop, full push+pop, drain in order
      for (int i = 0; i < 64; i++) push(8'(i), i[0]);
      check("t2_full", int'(buffer_occupancy), 64);
      store_tx_data = 1; tx_data = 8'hFF;
      tick();
      check("t2_ovf_occ", int'(buffer_occupancy), 64);
      store_tx_data = 1; tx_data = 8'hEE; get_tx_packet_data = 1;
      tick();
      check("t2_full_pp", int'(buffer_occupancy), 63);
      for (int i = 0; i < 63; i++) pop(i[0]);
      check("t2_empty", int'(buffer_occupancy), 0);
      check("t2_q_drained", exp_q.size(), 0);

      // T3: wrap across the 63->0 pointer boundary
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 40; i++) push(8'(8'h80 + r*40 + i), 1'(r));
         check("t3_occ40", int'(buffer_occupancy), 40);
         for (int i = 0; i < 40; i++) pop(1'(i % 3 == 0));
         check("t3_occ0", int'(buffer_occupancy), 0);
      end
      check("t3_q_drained", exp_q.size(), 0);

      // T4: simultaneous push+pop at 5 and at empty
      for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 0);
      store_tx_data = 1; tx_data = 8'h55; get_tx_packet_data = 1;
      exp_q.push_back(8'h55);
      tick();
      check("t4_occ5", int'(buffer_occupancy), 5);
      check("t4_head", int'(tx_packet_data), 8'h11);
      for (int i = 0; i < 5; i++) pop(0);
      check("t4_empty", int'(buffer_occupancy), 0);
      store_tx_data = 1; tx_data = 8'h66; get_rx_data = 1;
      exp_q.push_back(8'h66);
      tick();
      check("t4_occ1", int'(buffer_occupancy), 1);
      check("t4_head1", int'(rx_data), 8'h66);

      // T5: flush / clear override a same-cycle push
      for (int k = 0; k < 2; k++) begin
         while (buffer_occupancy < 7'd10) push(8'(8'h20 + buffer_occupancy), 1);
         check("t5_occ10", int'(buffer_occupancy), 10);
         if (k == 0) flush = 1; else clear = 1;
         store_rx_packet_data = 1; rx_packet_data = 8'h99;
         tick();
         exp_q.delete();
         check("t5_wiped", int'(buffer_occupancy), 0);
         push(8'h3C, 0);
         check("t5_head_after", int'(tx_packet_data), 8'h3C);
         pop(0);
      end

      // T6: async reset mid-cycle, then pop on empty
      for (int i = 0; i < 20; i++) push(8'(8'h40 + i), 0);
      check("t6_occ20", int'(buffer_occupancy), 20);
      @(posedge tb_clk); #3;
      n_rst = 0;
      #1;
      check("t6_rst_occ", int'(buffer_occupancy), 0);
      check("t6_rst_tx", int'(tx_packet_data), 0);
      exp_q.delete();
      @(negedge tb_clk); #2;
      n_rst = 1;
      @(posedge tb_clk); #1;
      pop(0);
      check("t6_empty_pop", int'(buffer_occupancy), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
